imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Sequences instruction-memory accesses for the fetch stage when the instruction memory has variable latency (cache or bus-attached ROM). Issues one request per fetch PC over a req/ack handshake and supplies the instruction to the fetch/decode register. Generates the fetch stall and decode bubble signals that the hazard logic ORs into its own stall/flush outputs. Also tracks wrong-path responses after a redirect and discards them.

## Interface
- DATA_W, 32, instruction and address width
- STALL_CNT_W, 32, width of memory-stall cycle counter
- DROP_CNT_W, 16, width of discarded-response counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- pc_f_i  in  DATA_W  current fetch PC from fetch PC register
- hazard_stall_i  in  1  hazard-unit stall of F and D; has priority over everything
- redirect_i  in  1  taken branch/jump resolved in D; PC register loads target at next edge unless stalled
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  DATA_W  request address; stable while imem_req_o=1 and no ack
- imem_ack_i  in  1  response valid; imem_rdata_i valid in same cycle
- imem_rdata_i  in  DATA_W  response data
- instr_f_o  out  DATA_W  instruction presented to decode register
- fetch_stall_o  out  1  freeze PC register (memory not ready)
- bubble_d_o  out  1  load a bubble into decode register this edge
- stall_cycles_o  out  STALL_CNT_W  cycles with fetch_stall_o=1 and hazard_stall_i=0, saturating
- drop_count_o  out  DROP_CNT_W  discarded responses, saturating

## Operation
- States: IDLE, FETCH, HOLD, DROP. Registers: state_q, pending_q, addr_q, buf_q, two counters.
- Reset (async): state IDLE, pending_q=0, addr_q=0, buf_q=0, counters 0. IDLE outputs: imem_req_o=0, fetch_stall_o=1, bubble_d_o=1, instr_f_o=0. IDLE→FETCH at first edge after rst_i falls.
- imem_addr_o = pending_q ? addr_q : pc_f_i. When imem_req_o=1 and pending_q=0, addr_q<=pc_f_i.
- redirect_i is ignored when hazard_stall_i=1, and is ignored in IDLE and DROP.
- FETCH: imem_req_o=1.
  - ack, hazard_stall_i=0: instr_f_o=imem_rdata_i, fetch_stall_o=0, bubble_d_o=0, pending_q<=0. Stay in FETCH. Redirect in the same cycle is treated identically; the pipeline flush discards the instruction.
  - ack, hazard_stall_i=1: buf_q<=imem_rdata_i, fetch_stall_o=1, bubble_d_o=0, go to HOLD.
  - no ack, redirect_i=1: fetch_stall_o=0 (PC loads target), bubble_d_o=1, pending_q<=1, go to DROP.
  - no ack, otherwise: fetch_stall_o=1, bubble_d_o=!hazard_stall_i, pending_q<=1.
- HOLD: imem_req_o=0, instr_f_o=buf_q, bubble_d_o=0.
  - fetch_stall_o=hazard_stall_i.
  - When hazard_stall_i=0: deliver buf_q, pending_q<=0, go to FETCH. Redirect is treated as a normal delivery.
- DROP: imem_req_o=1 with addr_q, fetch_stall_o=1, bubble_d_o=!hazard_stall_i, instr_f_o=0.
  - On ack: discard data, increment drop_count_o, pending_q<=0, go to FETCH. The next request uses the redirected pc_f_i.
- instr_f_o=0 in every cycle not listed as delivering.
- Counters saturate at all-ones and never wrap. Each counter increments at most once per cycle.

## Timing
- Zero-wait memory (ack tied high): one instruction per cycle, no stalls, counters stay 0.
- N-cycle memory: fetch_stall_o high for N−1 cycles per instruction. instr_f_o is valid in the ack cycle (combinational from imem_rdata_i).
- Redirect with a request outstanding: the PC updates at that edge. The wrong-path response is dropped on its ack. The target request launches the cycle after the drop ack.
- Request issue rules:
  - Never more than one outstanding request.
  - A new request may start the cycle after an ack.
  - imem_addr_o never changes between request start and ack.
- Reset asserted mid-request: state returns to IDLE immediately. A late ack arriving in IDLE is ignored and not counted.

## Test plan
- Ack tied high, PC 0x0,0x4,0x8: instr_f_o equals memory word each cycle; fetch_stall_o=0 after IDLE cycle; stall_cycles_o=0.
- 3-cycle latency at PC 0x100: imem_addr_o=0x100 for 3 cycles; fetch_stall_o=1,1,0; bubble_d_o=1,1,0; stall_cycles_o=2.
- Ack while hazard_stall_i=1 for 2 cycles: HOLD entered, imem_req_o=0. buf_q delivered when the stall drops. No second request to the same address.
- redirect_i in cycle 1 of 4-cycle fetch at 0x200 (target 0x400): fetch_stall_o=0 that cycle. imem_addr_o holds 0x200 until ack. The response is dropped and drop_count_o=1. The next request goes to 0x400.
- Counters preset near max (force to all-ones minus 1), 3 stall cycles: stall_cycles_o saturates at 0xFFFF_FFFF.
- rst_i pulsed during DROP: imem_req_o=0 immediately. All outputs take reset values. The first post-reset request uses pc_f_i.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Fetch-side instruction-memory sequencer. It keeps at most one req/ack access in flight,
// generates the fetch stall and decode bubble, and discards wrong-path responses after a redirect.
module imem_fetch_ctrl #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 32,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_W-1:0]      pc_f_i,
    input  logic                   hazard_stall_i,
    input  logic                   redirect_i,
    output logic                   imem_req_o,
    output logic [DATA_W-1:0]      imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [DATA_W-1:0]      imem_rdata_i,
    output logic [DATA_W-1:0]      instr_f_o,
    output logic                   fetch_stall_o,
    output logic                   bubble_d_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o,
    output logic [DROP_CNT_W-1:0]  drop_count_o,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_pending;
    logic [DATA_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_buf;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [DROP_CNT_W-1:0]  r_drop_cnt;

    logic                   w_req;
    logic                   w_stall;
    logic                   w_bubble;
    logic [DATA_W-1:0]      w_instr;
    logic                   w_redirect;
    logic                   w_stall_inc;
    logic                   w_drop_inc;

    // Handshake: a request is outstanding from the first cycle imem_req_o=1 until the cycle
    // imem_ack_i=1 while imem_req_o=1. The address is held in r_addr for that whole span.
    // An ack seen while imem_req_o=0 (IDLE, HOLD) is ignored.
    assign w_redirect  = redirect_i & ~hazard_stall_i;
    assign imem_addr_o = r_pending ? r_addr : pc_f_i;

    always_comb begin
        w_req    = 1'b0;
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        w_instr  = '0;
        case (r_state)
            ST_FETCH: begin
                w_req = 1'b1;
                if (imem_ack_i) begin
                    w_bubble = 1'b0;
                    if (!hazard_stall_i) begin
                        w_stall = 1'b0;
                        w_instr = imem_rdata_i;
                    end
                end else if (w_redirect) begin
                    w_stall = 1'b0;
                end else begin
                    w_bubble = ~hazard_stall_i;
                end
            end
            ST_HOLD: begin
                w_bubble = 1'b0;
                w_stall  = hazard_stall_i;
                w_instr  = r_buf;
            end
            ST_DROP: begin
                w_req    = 1'b1;
                w_bubble = ~hazard_stall_i;
            end
            default: ;
        endcase
    end

    // The post-reset IDLE cycle is not a memory wait, so it is kept out of the stall count.
    assign w_stall_inc = (r_state != ST_IDLE) && w_stall && !hazard_stall_i &&
                         (r_stall_cnt != {STALL_CNT_W{1'b1}});
    assign w_drop_inc  = (r_state == ST_DROP) && imem_ack_i &&
                         (r_drop_cnt != {DROP_CNT_W{1'b1}});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_addr      <= '0;
            r_buf       <= '0;
            r_stall_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_req && !r_pending) r_addr <= pc_f_i;
            if (w_stall_inc) r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            if (w_drop_inc)  r_drop_cnt  <= r_drop_cnt + DROP_CNT_W'(1);
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack_i) begin
                        r_pending <= 1'b0;
                        if (hazard_stall_i) begin
                            r_buf   <= imem_rdata_i;
                            r_state <= ST_HOLD;
                        end
                    end else begin
                        r_pending <= 1'b1;
                        if (w_redirect) r_state <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (!hazard_stall_i) begin
                        r_pending <= 1'b0;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (imem_ack_i) begin
                        r_pending <= 1'b0;
                        r_state   <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req_o     = w_req;
    assign instr_f_o      = w_instr;
    assign fetch_stall_o  = w_stall;
    assign bubble_d_o     = w_bubble;
    assign stall_cycles_o = r_stall_cnt;
    assign drop_count_o   = r_drop_cnt;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed scenarios plus a randomized run against a transaction-level model of the fetch
// controller (outstanding request, wrong-path flag, held instruction).
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        hs;
    logic        red;
    logic        ack;
    logic [31:0] rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        fstall;
    logic        bubble;
    logic [31:0] stall_cycles;
    logic [15:0] drop_count;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    imem_fetch_ctrl #(.DATA_W(32), .STALL_CNT_W(32), .DROP_CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .pc_f_i(pc_f), .hazard_stall_i(hs), .redirect_i(red),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
        .instr_f_o(instr), .fetch_stall_o(fstall), .bubble_d_o(bubble),
        .stall_cycles_o(stall_cycles), .drop_count_o(drop_count), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    logic        m_started, m_out, m_wrong, m_held;
    logic [31:0] m_out_addr, m_held_data, m_stall_cnt;
    logic [15:0] m_drop_cnt;
    logic        n_out, n_wrong, n_held, n_drop_inc, n_stall_inc;
    logic [31:0] n_out_addr, n_held_data;
    logic        e_req, e_stall, e_bubble;
    logic [31:0] e_addr, e_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic void model_eval();
        n_out = m_out; n_out_addr = m_out_addr; n_wrong = m_wrong;
        n_held = m_held; n_held_data = m_held_data; n_drop_inc = 1'b0;
        e_req = 1'b0; e_addr = pc_f; e_instr = '0; e_stall = 1'b1; e_bubble = 1'b1;
        if (!m_started) begin
            e_req = 1'b0;
        end else if (m_held) begin
            e_bubble = 1'b0; e_stall = hs; e_instr = m_held_data;
            if (!hs) n_held = 1'b0;
        end else begin
            e_req  = 1'b1;
            e_addr = m_out ? m_out_addr : pc_f;
            if (m_wrong) begin
                e_bubble = !hs;
                if (ack) begin n_wrong = 1'b0; n_out = 1'b0; n_drop_inc = 1'b1; end
                else begin n_out = 1'b1; n_out_addr = e_addr; end
            end else if (ack) begin
                n_out = 1'b0; e_bubble = 1'b0;
                if (hs) begin n_held = 1'b1; n_held_data = rdata; end
                else begin e_stall = 1'b0; e_instr = rdata; end
            end else begin
                n_out = 1'b1; n_out_addr = e_addr;
                if (red && !hs) begin e_stall = 1'b0; n_wrong = 1'b1; end
                else e_bubble = !hs;
            end
        end
        n_stall_inc = m_started && e_stall && !hs;
    endfunction

    function automatic void model_commit();
        m_started = 1'b1; m_out = n_out; m_out_addr = n_out_addr; m_wrong = n_wrong;
        m_held = n_held; m_held_data = n_held_data;
        if (n_stall_inc && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
        if (n_drop_inc && m_drop_cnt != 16'hFFFF) m_drop_cnt = m_drop_cnt + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_f = '0; hs = 1'b0; red = 1'b0; ack = 1'b0; rdata = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_f = 32'h1234; hs = 1'b0; red = 1'b0; ack = 1'b0; rdata = 32'hFFFF_FFFF;
        #2;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h expected 0", imem_req); end
        n_tests++; if (fstall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %0h expected 1", fstall); end
        n_tests++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble: got %0h expected 1", bubble); end
        n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr); end
        n_tests++; if (stall_cycles !== 32'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cycles); end
        n_tests++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %h expected 0", drop_count); end
        tick();
        rst = 1'b0;
        #2;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %0h expected 0", imem_req); end
        tick();
        #2;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h1234) begin
            n_fail++; $display("FAIL first_req: got req=%0h addr=%h expected req=1 addr=00001234", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pc_f = 32'(i * 4); ack = 1'b1; rdata = mem_word(32'(i * 4));
            #2;
            n_tests++; if (instr !== mem_word(32'(i * 4))) begin n_fail++; $display("FAIL zw_instr%0d: got %h expected %h", i, instr, mem_word(32'(i * 4))); end
            n_tests++; if (fstall !== 1'b0 || bubble !== 1'b0) begin n_fail++; $display("FAIL zw_ctrl%0d: got stall=%0h bubble=%0h expected 0 0", i, fstall, bubble); end
            n_tests++; if (imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL zw_addr%0d: got %h expected %h", i, imem_addr, 32'(i * 4)); end
            tick();
        end
        n_tests++; if (stall_cycles !== 32'h0) begin n_fail++; $display("FAIL zw_stall_cnt: got %0d expected 0", stall_cycles); end
    endtask

    task automatic test_latency3();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            pc_f = (c == 0) ? 32'h100 : 32'hBAD0 + 32'(c);
            ack = (c == 2); rdata = mem_word(32'h100);
            #2;
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL lat_addr%0d: got req=%0h addr=%h expected req=1 addr=00000100", c, imem_req, imem_addr); end
            n_tests++; if (fstall !== (c != 2)) begin n_fail++; $display("FAIL lat_stall%0d: got %0h expected %0h", c, fstall, (c != 2)); end
            n_tests++; if (bubble !== (c != 2)) begin n_fail++; $display("FAIL lat_bubble%0d: got %0h expected %0h", c, bubble, (c != 2)); end
            n_tests++; if (instr !== ((c == 2) ? mem_word(32'h100) : 32'h0)) begin n_fail++; $display("FAIL lat_instr%0d: got %h", c, instr); end
            tick();
        end
        n_tests++; if (stall_cycles !== 32'd2) begin n_fail++; $display("FAIL lat_stall_cnt: got %0d expected 2", stall_cycles); end
    endtask

    task automatic test_hold();
        do_reset();
        pc_f = 32'h300; hs = 1'b1; ack = 1'b1; rdata = 32'hCAFE_0300;
        #2;
        n_tests++; if (imem_req !== 1'b1 || fstall !== 1'b1 || bubble !== 1'b0 || instr !== 32'h0) begin
            n_fail++; $display("FAIL hold_ack: got req=%0h stall=%0h bubble=%0h instr=%h expected 1 1 0 0", imem_req, fstall, bubble, instr);
        end
        tick();
        ack = 1'b0; rdata = 32'h1111_1111;
        #2;
        n_tests++; if (imem_req !== 1'b0 || fstall !== 1'b1 || bubble !== 1'b0 || instr !== 32'hCAFE_0300) begin
            n_fail++; $display("FAIL hold_wait: got req=%0h stall=%0h bubble=%0h instr=%h expected 0 1 0 cafe0300", imem_req, fstall, bubble, instr);
        end
        tick();
        hs = 1'b0;
        #2;
        n_tests++; if (imem_req !== 1'b0 || fstall !== 1'b0 || bubble !== 1'b0 || instr !== 32'hCAFE_0300) begin
            n_fail++; $display("FAIL hold_deliver: got req=%0h stall=%0h bubble=%0h instr=%h expected 0 0 0 cafe0300", imem_req, fstall, bubble, instr);
        end
        tick();
        pc_f = 32'h304;
        #2;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin n_fail++; $display("FAIL hold_next: got req=%0h addr=%h expected 1 00000304", imem_req, imem_addr); end
        n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL hold_stall_cnt: got %0d expected 0", stall_cycles); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        pc_f = 32'h200; red = 1'b1; ack = 1'b0;
        #2;
        n_tests++; if (fstall !== 1'b0 || bubble !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL redir_cycle: got stall=%0h bubble=%0h addr=%h expected 0 1 00000200", fstall, bubble, imem_addr);
        end
        tick();
        pc_f = 32'h400; red = 1'b0;
        for (int c = 1; c < 4; c++) begin
            ack = (c == 3); rdata = 32'hBAD0_BAD0;
            #2;
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || fstall !== 1'b1 || bubble !== 1'b1 || instr !== 32'h0) begin
                n_fail++; $display("FAIL redir_drop%0d: got req=%0h addr=%h stall=%0h bubble=%0h instr=%h expected 1 00000200 1 1 0", c, imem_req, imem_addr, fstall, bubble, instr);
            end
            tick();
        end
        n_tests++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL redir_drop_cnt: got %0d expected 1", drop_count); end
        n_tests++; if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL redir_stall_cnt: got %0d expected 3", stall_cycles); end
        ack = 1'b0;
        #2;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin n_fail++; $display("FAIL redir_target: got req=%0h addr=%h expected 1 00000400", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        pc_f = 32'h500;
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_stall_cnt;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (stall_cycles !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_stall%0d: got %h expected ffffffff", c, stall_cycles); end
        end
        force dut.r_drop_cnt = 16'hFFFE;
        #1 release dut.r_drop_cnt;
        for (int d = 0; d < 2; d++) begin
            red = 1'b1; ack = 1'b0;
            tick();
            red = 1'b0; ack = 1'b1;
            tick();
            n_tests++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_drop%0d: got %h expected ffff", d, drop_count); end
        end
        ack = 1'b0;
    endtask

    task automatic test_reset_in_drop();
        do_reset();
        pc_f = 32'h600; red = 1'b1; ack = 1'b0;
        tick();
        pc_f = 32'h700; red = 1'b0;
        #2;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h600) begin n_fail++; $display("FAIL rdrop_pre: got req=%0h addr=%h expected 1 00000600", imem_req, imem_addr); end
        rst = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b0 || fstall !== 1'b1 || bubble !== 1'b1 || instr !== 32'h0) begin
            n_fail++; $display("FAIL rdrop_async: got req=%0h stall=%0h bubble=%0h instr=%h expected 0 1 1 0", imem_req, fstall, bubble, instr);
        end
        ack = 1'b1; rdata = 32'h7777_7777;
        tick();
        rst = 1'b0;
        #2;
        n_tests++; if (imem_req !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL rdrop_idle: got req=%0h instr=%h expected 0 0", imem_req, instr); end
        tick();
        ack = 1'b0;
        #2;
        n_tests++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rdrop_cnt: got %0d expected 0", drop_count); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h700) begin n_fail++; $display("FAIL rdrop_first: got req=%0h addr=%h expected 1 00000700", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        do_reset();
        m_started = 1'b1; m_out = 1'b0; m_wrong = 1'b0; m_held = 1'b0;
        m_out_addr = '0; m_held_data = '0; m_stall_cnt = '0; m_drop_cnt = '0;
        pc_f = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            hs    = ($urandom_range(0, 3) == 0);
            red   = ($urandom_range(0, 4) == 0);
            ack   = !m_held && ($urandom_range(0, 2) == 0);
            rdata = $urandom;
            tgt   = $urandom_range(0, 16383) << 2;
            model_eval();
            #2;
            n_tests++; if (imem_req !== e_req) begin n_fail++; $display("FAIL rnd_req@%0d: got %0h expected %0h", i, imem_req, e_req); end
            n_tests++; if (e_req && imem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h expected %h", i, imem_addr, e_addr); end
            n_tests++; if (instr !== e_instr) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h expected %h", i, instr, e_instr); end
            n_tests++; if (fstall !== e_stall || bubble !== e_bubble) begin
                n_fail++; $display("FAIL rnd_ctrl@%0d: got stall=%0h bubble=%0h expected %0h %0h", i, fstall, bubble, e_stall, e_bubble);
            end
            n_tests++; if (stall_cycles !== m_stall_cnt || drop_count !== m_drop_cnt) begin
                n_fail++; $display("FAIL rnd_cnt@%0d: got stall=%0d drop=%0d expected %0d %0d", i, stall_cycles, drop_count, m_stall_cnt, m_drop_cnt);
            end
            tick();
            if (!(hs || e_stall)) pc_f = red ? tgt : pc_f + 32'd4;
            model_commit();
        end
        hs = 1'b0; red = 1'b0; ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency3();
        test_hold();
        test_redirect();
        test_saturate();
        test_reset_in_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
